// File: rtl/serieller_subtrahierer_pkg.sv
// Shared constants for the bit-serial subtractor: state encoding and default width.
package serieller_subtrahierer_pkg;

  localparam int BREITE_STANDARD = 8;

  localparam logic [1:0] ZUSTAND_LEER    = 2'd0;
  localparam logic [1:0] ZUSTAND_RECHNEN = 2'd1;
  localparam logic [1:0] ZUSTAND_FERTIG  = 2'd2;

  typedef enum logic [1:0] {
    LEER    = ZUSTAND_LEER,
    RECHNEN = ZUSTAND_RECHNEN,
    FERTIG  = ZUSTAND_FERTIG
  } zustand_t;

endpackage

// File: rtl/serieller_subtrahierer_vollsubtrahierer.sv
// Single full-subtractor cell: d = x - y - bin, bout set when the difference goes negative.
module vollsubtrahierer (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serieller_subtrahierer.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell,
// with a start/bereit and fertig/quittung handshake.
module serieller_subtrahierer
  import serieller_subtrahierer_pkg::*;
#(
  parameter int BREITE = BREITE_STANDARD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BREITE-1:0] a,
  input  logic [BREITE-1:0] b,
  output logic              bereit,
  output logic              fertig,
  input  logic              quittung,
  output logic [BREITE-1:0] differenz,
  output logic              borgen,
  output logic              ueberlauf
);

  localparam int ZW = $clog2(BREITE);
  localparam logic [ZW-1:0] LETZTER = ZW'(BREITE - 1);

  zustand_t          zustand, naechster;
  logic [BREITE-1:0] a_sr, b_sr;
  logic [BREITE-2:0] erg_sr;
  logic [BREITE-1:0] erg_neu;
  logic [ZW-1:0]     zaehler;
  logic              borrow_ff;
  logic              d_bit, bout_bit;

  vollsubtrahierer u_zelle (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bin (borrow_ff),
    .d   (d_bit),
    .bout(bout_bit)
  );

  // Result bits collected so far with the newest bit on top; the full word on the last step.
  assign erg_neu = {d_bit, erg_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zustand <= LEER;
    else        zustand <= naechster;
  end

  always_comb begin
    naechster = zustand;
    bereit    = 1'b0;
    fertig    = 1'b0;
    case (zustand)
      LEER: begin
        bereit = 1'b1;
        if (start) naechster = RECHNEN;
      end
      RECHNEN: begin
        if (zaehler == LETZTER) naechster = FERTIG;
      end
      FERTIG: begin
        fertig = 1'b1;
        if (quittung) naechster = LEER;
      end
      default: naechster = LEER;
    endcase
  end

  // On the last step a_sr[0]/b_sr[0] hold the captured MSBs, so overflow uses them directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      erg_sr    <= '0;
      zaehler   <= '0;
      borrow_ff <= 1'b0;
      differenz <= '0;
      borgen    <= 1'b0;
      ueberlauf <= 1'b0;
    end else if (zustand == LEER && start) begin
      a_sr      <= a;
      b_sr      <= b;
      borrow_ff <= 1'b0;
      zaehler   <= '0;
    end else if (zustand == RECHNEN) begin
      a_sr      <= a_sr >> 1;
      b_sr      <= b_sr >> 1;
      erg_sr    <= erg_neu[BREITE-1:1];
      borrow_ff <= bout_bit;
      zaehler   <= zaehler + 1'b1;
      if (zaehler == LETZTER) begin
        differenz <= erg_neu;
        borgen    <= bout_bit;
        ueberlauf <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d_bit);
      end
    end
  end

endmodule
